// File: rtl/mem_defines.sv
// Shared TCM constants, tag type and arbiter grant encoding.
package mem_defines;

   localparam logic [31:0] TCM_BASE  = 32'h0001_0000;
   localparam int unsigned TCM_WORDS = 16384;

   typedef logic [10:0] tcm_tag_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_I    = 2'd1,
      GNT_D    = 2'd2
   } arb_grant_e;

endpackage

// File: rtl/tcm_arb_pick.sv
// Grant selection for the TCM port: D wins over I, combinational, one grant per cycle.
// With TCM_ARB_STARVE_EN a streak counter forces an I grant after D_STREAK_MAX contended D grants.
module tcm_arb_pick
   import mem_defines::*;
#(
   parameter int unsigned D_STREAK_MAX = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       i_req_i,
   input  logic       d_req_i,
   output arb_grant_e gnt_o
);

`ifdef TCM_ARB_STARVE_EN
   localparam int unsigned CW = $clog2(D_STREAK_MAX + 1);

   logic [CW-1:0] streak_q, streak_d;
   logic          force_i;

   assign force_i = i_req_i && (streak_q == CW'(D_STREAK_MAX));

   always_comb begin
      gnt_o = GNT_NONE;
      if (d_req_i && !force_i) begin
         gnt_o = GNT_D;
      end else if (i_req_i) begin
         gnt_o = GNT_I;
      end
   end

   // Only D grants that made I wait extend the streak; anything else restarts it.
   always_comb begin
      streak_d = '0;
      if (i_req_i && (gnt_o == GNT_D)) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end
`else
   logic [31:0] unused_cfg;
   assign unused_cfg = 32'(D_STREAK_MAX) ^ {30'd0, clk_i, rst_ni};

   always_comb begin
      gnt_o = GNT_NONE;
      if (d_req_i) begin
         gnt_o = GNT_D;
      end else if (i_req_i) begin
         gnt_o = GNT_I;
      end
   end
`endif

endmodule

// File: rtl/tcm_port_arb.sv
// Single-port TCM shared by fetch and data ports; combinational accept, responses 1 cycle later.
// No queuing: a losing requester holds its request. Optional I anti-starvation via TCM_ARB_STARVE_EN.
module tcm_port_arb
   import mem_defines::*;
#(
   parameter logic [31:0] BASE_ADDR    = TCM_BASE,
   parameter int unsigned SIZE_WORDS   = TCM_WORDS,
   parameter int unsigned AW           = $clog2(SIZE_WORDS),
   parameter int unsigned D_STREAK_MAX = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,

   input  logic          mem_i_rd_i,
   input  logic [31:0]   mem_i_pc_i,
   input  logic          mem_i_flush_i,
   input  logic          mem_i_invalidate_i,
   output logic          mem_i_accept_o,
   output logic          mem_i_valid_o,
   output logic          mem_i_error_o,
   output logic [31:0]   mem_i_inst_o,

   input  logic [31:0]   mem_d_addr_i,
   input  logic [31:0]   mem_d_data_wr_i,
   input  logic          mem_d_rd_i,
   input  logic [3:0]    mem_d_wr_i,
   input  tcm_tag_t      mem_d_req_tag_i,
   input  logic          mem_d_cacheable_i,
   input  logic          mem_d_flush_i,
   input  logic          mem_d_invalidate_i,
   input  logic          mem_d_writeback_i,
   output logic          mem_d_accept_o,
   output logic          mem_d_ack_o,
   output logic          mem_d_error_o,
   output logic [31:0]   mem_d_data_rd_o,
   output tcm_tag_t      mem_d_resp_tag_o,

   output logic          sram_cs_o,
   output logic [3:0]    sram_we_o,
   output logic [AW-1:0] sram_addr_o,
   output logic [31:0]   sram_wdata_o,
   input  logic [31:0]   sram_rdata_i
);

   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * SIZE_WORDS);

   function automatic logic in_range(input logic [31:0] a);
      return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
   endfunction

   function automatic logic [AW-1:0] word_addr(input logic [31:0] a);
      return AW'((a - BASE_ADDR) >> 2);
   endfunction

   logic       unused_in;
   logic       i_req, d_req, d_acc, i_in, d_in;
   arb_grant_e gnt;

   logic       resp_i_q, resp_i_d;
   logic       resp_d_q, resp_d_d;
   logic       err_q, err_d;
   logic       rdat_q, rdat_d;
   tcm_tag_t   tag_q, tag_d;

   assign unused_in = mem_i_flush_i ^ mem_i_invalidate_i ^ mem_d_cacheable_i;

   assign d_acc = mem_d_rd_i | (|mem_d_wr_i);
   assign d_req = rst_ni & (d_acc | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i);
   assign i_req = rst_ni & mem_i_rd_i;
   assign i_in  = in_range(mem_i_pc_i);
   assign d_in  = in_range(mem_d_addr_i);

   tcm_arb_pick #(
      .D_STREAK_MAX (D_STREAK_MAX)
   ) u_pick (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_req_i (i_req),
      .d_req_i (d_req),
      .gnt_o   (gnt)
   );

   assign mem_i_accept_o = rst_ni && (gnt == GNT_I);
   assign mem_d_accept_o = rst_ni && (gnt == GNT_D);

   always_comb begin
      sram_cs_o    = 1'b0;
      sram_we_o    = '0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      resp_i_d     = 1'b0;
      resp_d_d     = 1'b0;
      err_d        = 1'b0;
      rdat_d       = 1'b0;
      tag_d        = '0;
      case (gnt)
         GNT_I: begin
            resp_i_d = 1'b1;
            err_d    = !i_in;
            if (i_in) begin
               sram_cs_o   = 1'b1;
               sram_addr_o = word_addr(mem_i_pc_i);
               rdat_d      = 1'b1;
            end
         end
         GNT_D: begin
            resp_d_d = 1'b1;
            tag_d    = mem_d_req_tag_i;
            // Maintenance-only requests skip the range check and the SRAM.
            if (d_acc) begin
               err_d = !d_in;
               if (d_in) begin
                  sram_cs_o    = 1'b1;
                  sram_we_o    = mem_d_wr_i;
                  sram_addr_o  = word_addr(mem_d_addr_i);
                  sram_wdata_o = mem_d_data_wr_i;
                  rdat_d       = ~|mem_d_wr_i;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         resp_i_q <= 1'b0;
         resp_d_q <= 1'b0;
         err_q    <= 1'b0;
         rdat_q   <= 1'b0;
         tag_q    <= '0;
      end else begin
         resp_i_q <= resp_i_d;
         resp_d_q <= resp_d_d;
         err_q    <= err_d;
         rdat_q   <= rdat_d;
         tag_q    <= tag_d;
      end
   end

   // Gating with rst_ni hides a response registered just before reset asserted.
   assign mem_i_valid_o    = rst_ni & resp_i_q;
   assign mem_i_error_o    = rst_ni & resp_i_q & err_q;
   assign mem_i_inst_o     = (rst_ni & resp_i_q & rdat_q) ? sram_rdata_i : 32'd0;
   assign mem_d_ack_o      = rst_ni & resp_d_q;
   assign mem_d_error_o    = rst_ni & resp_d_q & err_q;
   assign mem_d_data_rd_o  = (rst_ni & resp_d_q & rdat_q) ? sram_rdata_i : 32'd0;
   assign mem_d_resp_tag_o = (rst_ni & resp_d_q) ? tag_q : '0;

endmodule

// File: tb/tb_tcm_port_arb.sv
// Bench for tcm_port_arb: directed scenarios then random traffic against a word-array reference model.
module tb_tcm_port_arb;

   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam int unsigned SIZE = 16384;
   localparam int unsigned DSM  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_ni;
   logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
   logic [31:0] mem_i_pc_i;
   logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
   logic [31:0] mem_i_inst_o;
   logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
   logic        mem_d_rd_i;
   logic [3:0]  mem_d_wr_i;
   logic [10:0] mem_d_req_tag_i;
   logic        mem_d_cacheable_i, mem_d_flush_i, mem_d_invalidate_i, mem_d_writeback_i;
   logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
   logic [31:0] mem_d_data_rd_o;
   logic [10:0] mem_d_resp_tag_o;
   logic        sram_cs_o;
   logic [3:0]  sram_we_o;
   logic [13:0] sram_addr_o;
   logic [31:0] sram_wdata_o;
   logic [31:0] sram_rdata;

   tcm_port_arb #(
      .BASE_ADDR    (BASE),
      .SIZE_WORDS   (SIZE),
      .AW           (14),
      .D_STREAK_MAX (DSM)
   ) dut (
      .clk_i              (clk),
      .rst_ni             (rst_ni),
      .mem_i_rd_i         (mem_i_rd_i),
      .mem_i_pc_i         (mem_i_pc_i),
      .mem_i_flush_i      (mem_i_flush_i),
      .mem_i_invalidate_i (mem_i_invalidate_i),
      .mem_i_accept_o     (mem_i_accept_o),
      .mem_i_valid_o      (mem_i_valid_o),
      .mem_i_error_o      (mem_i_error_o),
      .mem_i_inst_o       (mem_i_inst_o),
      .mem_d_addr_i       (mem_d_addr_i),
      .mem_d_data_wr_i    (mem_d_data_wr_i),
      .mem_d_rd_i         (mem_d_rd_i),
      .mem_d_wr_i         (mem_d_wr_i),
      .mem_d_req_tag_i    (mem_d_req_tag_i),
      .mem_d_cacheable_i  (mem_d_cacheable_i),
      .mem_d_flush_i      (mem_d_flush_i),
      .mem_d_invalidate_i (mem_d_invalidate_i),
      .mem_d_writeback_i  (mem_d_writeback_i),
      .mem_d_accept_o     (mem_d_accept_o),
      .mem_d_ack_o        (mem_d_ack_o),
      .mem_d_error_o      (mem_d_error_o),
      .mem_d_data_rd_o    (mem_d_data_rd_o),
      .mem_d_resp_tag_o   (mem_d_resp_tag_o),
      .sram_cs_o          (sram_cs_o),
      .sram_we_o          (sram_we_o),
      .sram_addr_o        (sram_addr_o),
      .sram_wdata_o       (sram_wdata_o),
      .sram_rdata_i       (sram_rdata)
   );

   // Write-first SRAM macro model.
   bit   [31:0] sram [SIZE];
   logic [31:0] sram_w;
   always @(posedge clk) begin
      if (sram_cs_o) begin
         sram_w = sram[sram_addr_o];
         for (int b = 0; b < 4; b++)
            if (sram_we_o[b]) sram_w[8*b +: 8] = sram_wdata_o[8*b +: 8];
         sram[sram_addr_o] <= sram_w;
         sram_rdata        <= sram_w;
      end
   end

   int checks = 0;
   int errors = 0;

   // Reference state: expected memory contents and the response due next cycle.
   bit   [31:0] golden [SIZE];
   logic        p_iv, p_ierr, p_dv, p_derr;
   logic [31:0] p_inst, p_data;
   logic [10:0] p_tag;
   int          streak = 0;
   logic        last_i_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit inr(input logic [31:0] a);
      longint la = longint'(a);
      return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(SIZE));
   endfunction

   function automatic logic [13:0] widx(input logic [31:0] a);
      return 14'((a - BASE) >> 2);
   endfunction

   task automatic clear_pending();
      p_iv = 0; p_ierr = 0; p_dv = 0; p_derr = 0;
      p_inst = 0; p_data = 0; p_tag = 0;
   endtask

   // Checks one cycle at the falling edge, then advances to just after the next rising edge.
   task automatic tick();
      bit          d_acc, d_req, i_req;
      int          gnt;
      logic        cs_e;
      logic [3:0]  we_e;
      logic [13:0] a_e;
      logic [31:0] wd_e;
      @(negedge clk);
      if (!rst_ni) begin
         clear_pending();
         streak = 0;
      end
      chk("i_valid", 32'(mem_i_valid_o), 32'(p_iv));
      chk("d_ack", 32'(mem_d_ack_o), 32'(p_dv));
      if (p_iv) begin
         chk("i_error", 32'(mem_i_error_o), 32'(p_ierr));
         chk("i_inst", mem_i_inst_o, p_inst);
      end
      if (p_dv) begin
         chk("d_error", 32'(mem_d_error_o), 32'(p_derr));
         chk("d_data", mem_d_data_rd_o, p_data);
         chk("d_tag", 32'(mem_d_resp_tag_o), 32'(p_tag));
      end
      if (!rst_ni) begin
         chk("rst_i_accept", 32'(mem_i_accept_o), 0);
         chk("rst_d_accept", 32'(mem_d_accept_o), 0);
         chk("rst_outs", {mem_i_error_o, mem_d_error_o, sram_cs_o, sram_we_o, mem_d_resp_tag_o}, 0);
         chk("rst_inst", mem_i_inst_o, 0);
         chk("rst_data", mem_d_data_rd_o, 0);
         chk("rst_sram_addr", 32'(sram_addr_o), 0);
         chk("rst_sram_wdata", sram_wdata_o, 0);
         last_i_acc = 0;
      end else begin
         d_acc = mem_d_rd_i || (mem_d_wr_i != 0);
         d_req = d_acc || mem_d_flush_i || mem_d_invalidate_i || mem_d_writeback_i;
         i_req = mem_i_rd_i;
         gnt   = d_req ? 2 : (i_req ? 1 : 0);
`ifdef TCM_ARB_STARVE_EN
         if (d_req && i_req && streak == DSM) gnt = 1;
`endif
         streak = (i_req && gnt == 2) ? streak + 1 : 0;
         chk("i_accept", 32'(mem_i_accept_o), 32'(gnt == 1));
         chk("d_accept", 32'(mem_d_accept_o), 32'(gnt == 2));
         clear_pending();
         cs_e = 0; we_e = 0; a_e = 0; wd_e = 0;
         if (gnt == 1) begin
            p_iv = 1;
            if (inr(mem_i_pc_i)) begin
               cs_e = 1; a_e = widx(mem_i_pc_i); p_inst = golden[a_e];
            end else p_ierr = 1;
         end
         if (gnt == 2) begin
            p_dv  = 1;
            p_tag = mem_d_req_tag_i;
            if (d_acc) begin
               if (inr(mem_d_addr_i)) begin
                  cs_e = 1; we_e = mem_d_wr_i; a_e = widx(mem_d_addr_i); wd_e = mem_d_data_wr_i;
                  if (we_e != 0) begin
                     for (int b = 0; b < 4; b++)
                        if (we_e[b]) golden[a_e][8*b +: 8] = wd_e[8*b +: 8];
                  end else p_data = golden[a_e];
               end else p_derr = 1;
            end
         end
         chk("sram_cs", 32'(sram_cs_o), 32'(cs_e));
         if (cs_e) begin
            chk("sram_addr", 32'(sram_addr_o), 32'(a_e));
            chk("sram_we", 32'(sram_we_o), 32'(we_e));
            if (we_e != 0) chk("sram_wdata", sram_wdata_o, wd_e);
         end
         last_i_acc = mem_i_accept_o;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_i_rd_i = 0; mem_i_pc_i = 0; mem_i_flush_i = 0; mem_i_invalidate_i = 0;
      mem_d_addr_i = 0; mem_d_data_wr_i = 0; mem_d_rd_i = 0; mem_d_wr_i = 0;
      mem_d_req_tag_i = 0; mem_d_cacheable_i = 0; mem_d_flush_i = 0;
      mem_d_invalidate_i = 0; mem_d_writeback_i = 0;
   endtask

   task automatic d_op(input logic [31:0] a, input logic rd, input logic [3:0] wr,
                       input logic [31:0] wd, input logic [10:0] tg);
      mem_d_addr_i = a; mem_d_rd_i = rd; mem_d_wr_i = wr;
      mem_d_data_wr_i = wd; mem_d_req_tag_i = tg;
   endtask

   initial begin
      int first_i;
      int r;
      clear_pending();
      rst_ni = 0;
      idle();
      tick(); tick();

      // Fetch in the first cycle after reset release.
      rst_ni = 1;
      mem_i_rd_i = 1; mem_i_pc_i = BASE + 32'h4;
      tick();
      idle();
      d_op(BASE + 32'h4, 0, 4'hF, 32'hDEAD_BEEF, 11'h001);
      tick();
      idle();
      mem_i_rd_i = 1; mem_i_pc_i = BASE + 32'h4;
      tick();
      idle();
      chk("fetch_valid", 32'(mem_i_valid_o), 1);
      chk("fetch_inst", mem_i_inst_o, 32'hDEAD_BEEF);
      chk("fetch_err", 32'(mem_i_error_o), 0);
      tick();

      // Partial write then read-after-write.
      d_op(BASE + 32'h10, 0, 4'hF, 32'h1122_3344, 11'h002); tick();
      d_op(BASE + 32'h10, 0, 4'b0011, 32'hA5A5_A5A5, 11'h003); tick();
      d_op(BASE + 32'h10, 1, 4'h0, 32'h0, 11'h155); tick();
      idle();
      chk("raw_ack", 32'(mem_d_ack_o), 1);
      chk("raw_data", mem_d_data_rd_o, 32'h1122_A5A5);
      chk("raw_tag", 32'(mem_d_resp_tag_o), 32'h155);
      tick();

      // Contended I and D for six cycles.
      first_i = 0;
      for (int c = 1; c <= 6; c++) begin
         mem_i_rd_i = 1; mem_i_pc_i = BASE;
         d_op(BASE + 32'h20, 1, 4'h0, 32'h0, 11'(c));
         tick();
         if (last_i_acc && first_i == 0) first_i = c;
      end
      idle();
`ifdef TCM_ARB_STARVE_EN
      chk("starve_first_i", first_i, 5);
`else
      chk("starve_first_i", first_i, 0);
`endif
      tick();

      // Range boundaries: below base, past the end, last word.
      d_op(32'h0, 1, 4'h0, 32'h0, 11'h7FF); tick();
      idle();
      chk("oor_ack", 32'(mem_d_ack_o), 1);
      chk("oor_err", 32'(mem_d_error_o), 1);
      chk("oor_data", mem_d_data_rd_o, 0);
      d_op(BASE + 4 * SIZE, 0, 4'hF, 32'h1234_5678, 11'h010); tick();
      d_op(BASE + 4 * SIZE - 4, 0, 4'hF, 32'hCAFE_F00D, 11'h011); tick();
      idle();
      mem_i_rd_i = 1; mem_i_pc_i = BASE + 4 * SIZE; tick();
      mem_i_pc_i = BASE + 4 * SIZE - 1; tick();
      idle();
      chk("last_word_inst", mem_i_inst_o, 32'hCAFE_F00D);
      tick();

      // Maintenance pulse.
      mem_d_flush_i = 1; mem_d_req_tag_i = 11'h0AA; tick();
      idle();
      chk("flush_ack", 32'(mem_d_ack_o), 1);
      chk("flush_err", 32'(mem_d_error_o), 0);
      tick();

      // Reset in the cycle after an accept drops the response.
      mem_i_rd_i = 1; mem_i_pc_i = BASE + 32'h4; tick();
      idle();
      rst_ni = 0; tick();
      rst_ni = 1;
      chk("rst_drop_valid", 32'(mem_i_valid_o), 0);
      tick();

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         idle();
         rst_ni = ($urandom_range(0, 99) != 0);
         r = $urandom_range(0, 9);
         case (r)
            0: mem_d_addr_i = $urandom_range(0, 32'hFFFF);
            1: mem_d_addr_i = BASE + 4 * SIZE + $urandom_range(0, 64);
            2: mem_d_addr_i = BASE + 4 * SIZE - 4 + $urandom_range(0, 3);
            default: mem_d_addr_i = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
         endcase
         r = $urandom_range(0, 9);
         if (r < 3) mem_d_rd_i = 1;
         else if (r < 6) mem_d_wr_i = 4'($urandom_range(1, 15));
         else if (r == 6) begin
            mem_d_flush_i = $urandom_range(0, 1); mem_d_invalidate_i = $urandom_range(0, 1);
            mem_d_writeback_i = 1;
         end
         mem_d_data_wr_i   = $urandom;
         mem_d_req_tag_i   = 11'($urandom);
         mem_d_cacheable_i = $urandom_range(0, 1);
         mem_i_rd_i        = $urandom_range(0, 1);
         mem_i_pc_i        = ($urandom_range(0, 7) == 0) ? $urandom
                                                         : BASE + 4 * $urandom_range(0, 15);
         mem_i_flush_i      = $urandom_range(0, 1);
         mem_i_invalidate_i = $urandom_range(0, 1);
         tick();
      end
      idle();
      rst_ni = 1;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
